// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions for the host transmit and device receive paths.
package ps2_pkg;

  // Host transmit FSM states
  typedef enum logic [2:0] {
    StIdle,
    StInhibit,
    StRts,
    StShift,
    StAck
  } ps2_tx_state_e;

  // Frame layout: start, 8 data bits LSB first, odd parity, stop -> 11 device clocks
  localparam int unsigned FrameClocks = 11;
  localparam int unsigned DataBits    = 8;
  localparam int unsigned ParityIdx   = 8;
  localparam int unsigned StopIdx     = 9;

  // 100 us inhibit and 20 ms reply window at 50 MHz
  localparam int unsigned InhibitCyclesDefault = 5000;
  localparam int unsigned TimeoutCyclesDefault = 1_000_000;

  // Odd parity: the parity bit makes the total number of ones odd
  function automatic logic odd_parity(input logic [DataBits-1:0] data);
    return ~^data;
  endfunction

endpackage

// File: rtl/ps2_line_sync.sv
// Two-flop synchronizer for one PS/2 pad line plus a falling-edge detector.
module ps2_line_sync (
  input  logic clk_i,
  input  logic rst_i,
  input  logic line_i,
  output logic sync_o,
  output logic fall_o
);

  // [0],[1] form the synchronizer, [2] holds the previous synchronized value
  logic [2:0] sync_q;

  // Shift the pad level in; idle-high lines reset to 1 so no false edge appears
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      sync_q <= 3'b111;
    end else begin
      sync_q <= {sync_q[1:0], line_i};
    end
  end

  assign sync_o = sync_q[1];
  assign fall_o = sync_q[2] & ~sync_q[1];

endmodule

// File: rtl/ps2_host_tx.sv
// PS/2 host-to-device transmitter: inhibit, request-to-send, shift frame, sample ack.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = InhibitCyclesDefault,
  parameter int unsigned TIMEOUT_CYCLES = TimeoutCyclesDefault
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       start,
  input  logic [7:0] tx_data,
  input  logic       ps2c,
  input  logic       ps2d,
  output logic       ps2c_low,
  output logic       ps2d_low,
  output logic       busy,
  output logic       done,
  output logic       ack_err,
  output logic       timeout
);

  localparam int unsigned InhW = (INHIBIT_CYCLES > 1) ? $clog2(INHIBIT_CYCLES) : 1;
  localparam int unsigned TmoW = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [InhW-1:0] InhLast  = InhW'(INHIBIT_CYCLES - 1);
  localparam logic [TmoW-1:0] TmoLast  = TmoW'(TIMEOUT_CYCLES - 1);
  localparam logic [3:0]      StopLast = 4'(StopIdx);

  logic c_sync, c_fall, d_sync, d_fall;
  logic unused_lines;

  ps2_line_sync u_sync_c (
    .clk_i  (CLK),
    .rst_i  (RST),
    .line_i (ps2c),
    .sync_o (c_sync),
    .fall_o (c_fall)
  );

  ps2_line_sync u_sync_d (
    .clk_i  (CLK),
    .rst_i  (RST),
    .line_i (ps2d),
    .sync_o (d_sync),
    .fall_o (d_fall)
  );

  // Only the clock edge and the data level are needed when transmitting
  assign unused_lines = c_sync ^ d_fall;

  ps2_tx_state_e   state_q;
  logic [InhW-1:0] inh_cnt_q;
  logic [TmoW-1:0] tmo_cnt_q;
  logic [3:0]      bit_idx_q;
  logic [9:0]      frame_q;  // {stop, parity, data}, shifted out LSB first
  logic            ps2c_low_q, ps2d_low_q, busy_q, done_q, ack_err_q, timeout_q;

  // Transmit FSM with registered line drives and status pulses
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      state_q    <= StIdle;
      inh_cnt_q  <= '0;
      tmo_cnt_q  <= '0;
      bit_idx_q  <= '0;
      frame_q    <= '0;
      ps2c_low_q <= 1'b0;
      ps2d_low_q <= 1'b0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      ack_err_q  <= 1'b0;
      timeout_q  <= 1'b0;
    end else begin
      done_q    <= 1'b0;
      ack_err_q <= 1'b0;
      timeout_q <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (start) begin
            frame_q    <= {1'b1, odd_parity(tx_data), tx_data};
            inh_cnt_q  <= '0;
            ps2c_low_q <= 1'b1;
            ps2d_low_q <= 1'b0;
            busy_q     <= 1'b1;
            state_q    <= StInhibit;
          end
        end
        StInhibit: begin
          if (inh_cnt_q == InhLast) begin
            ps2c_low_q <= 1'b0;
            ps2d_low_q <= 1'b1;  // start bit, clock released
            tmo_cnt_q  <= '0;
            state_q    <= StRts;
          end else begin
            inh_cnt_q <= inh_cnt_q + InhW'(1);
          end
        end
        StRts, StShift, StAck: begin
          tmo_cnt_q <= tmo_cnt_q + TmoW'(1);
          // Ack edge beats a coincident timeout
          if (state_q == StAck && c_fall) begin
            done_q     <= 1'b1;
            ack_err_q  <= d_sync;
            busy_q     <= 1'b0;
            ps2c_low_q <= 1'b0;
            ps2d_low_q <= 1'b0;
            state_q    <= StIdle;
          end else if (tmo_cnt_q == TmoLast) begin
            timeout_q  <= 1'b1;
            busy_q     <= 1'b0;
            ps2c_low_q <= 1'b0;
            ps2d_low_q <= 1'b0;
            state_q    <= StIdle;
          end else if (state_q == StRts) begin
            bit_idx_q <= '0;
            state_q   <= StShift;
          end else if (state_q == StShift && c_fall) begin
            ps2d_low_q <= ~frame_q[0];
            frame_q    <= {1'b1, frame_q[9:1]};
            bit_idx_q  <= bit_idx_q + 4'd1;
            if (bit_idx_q == StopLast) begin
              state_q <= StAck;
            end
          end
        end
        default: state_q <= StIdle;
      endcase
    end
  end

  assign ps2c_low = ps2c_low_q;
  assign ps2d_low = ps2d_low_q;
  assign busy     = busy_q;
  assign done     = done_q;
  assign ack_err  = ack_err_q;
  assign timeout  = timeout_q;

endmodule
